// File: rtl/sp_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_be
// Purpose  : Single-port byte-enable RAM with configurable read latency,
//            write mode and auto-clear FSM. Optional parity: SP_RAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_be #(
    parameter int                   G_ADDR       = 10,
    parameter int                   G_BYTES      = 2,
    parameter int                   G_DEPTH      = 2**G_ADDR,
    parameter int                   G_PIPELINE   = 1,
    parameter string                G_WR_MODE    = "NO_CHANGE",
    parameter int                   G_CLR_ON_RST = 1,
    parameter logic [8*G_BYTES-1:0] G_RST_VAL    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   clrrdy,
    input  logic                   req,
    input  logic                   we,
    input  logic [G_BYTES-1:0]     be,
    input  logic [G_ADDR-1:0]      addr,
    input  logic [8*G_BYTES-1:0]   din,
    output logic [8*G_BYTES-1:0]   dout,
    output logic                   dvld,
    output logic [G_BYTES-1:0]     perr
);

    localparam int               c_WIDTH = 8*G_BYTES;
    localparam int               c_IW    = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
    localparam logic [c_IW-1:0]  c_LAST  = c_IW'(G_DEPTH-1);
    localparam bit               c_WF    = (G_WR_MODE == "WRITE_FIRST");
    localparam bit               c_RF    = (G_WR_MODE == "READ_FIRST");

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (G_CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;

    state_t                r_state, w_state_nxt;
    logic [c_IW-1:0]       r_clr_addr, w_clr_addr_nxt;

    logic [c_WIDTH-1:0]    r_mem [G_DEPTH];
    logic [c_IW-1:0]       w_idx;
    logic                  w_in_rng, w_acc, w_wr, w_clr_wr, w_vld_in;
    logic [c_WIDTH-1:0]    w_mask, w_old, w_new, w_dat_in;
    logic [G_BYTES-1:0]    w_perr_in;

    logic                  r_vld_pipe  [G_PIPELINE];
    logic [c_WIDTH-1:0]    r_dat_pipe  [G_PIPELINE];
    logic [G_BYTES-1:0]    r_perr_pipe [G_PIPELINE];

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_RST_STATE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_IDLE: begin
                if (clr) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                // Terminal compare instead of wrap: depth need not be a power of two
                if (r_clr_addr == c_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + c_IW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clrrdy   = (r_state == S_IDLE);
    // rst_n gating keeps the array untouched while reset is held
    assign w_clr_wr = (r_state == S_CLEAR) && rst_n;
    assign w_acc    = req && clrrdy && rst_n;

    // ---------------- access datapath ----------------
    assign w_idx    = addr[c_IW-1:0];
    assign w_in_rng = ({1'b0, addr} < (G_ADDR+1)'(G_DEPTH));
    assign w_wr     = w_acc && we && w_in_rng;

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < G_BYTES; b++) w_mask[8*b +: 8] = {8{be[b]}};
    end

    assign w_old    = w_in_rng ? r_mem[w_idx] : G_RST_VAL;
    assign w_new    = (w_old & ~w_mask) | (din & w_mask);
    assign w_vld_in = w_acc && (!we || c_WF || c_RF);
    assign w_dat_in = (we && c_WF) ? w_new : w_old;

    always_ff @(posedge clk) begin
        if (w_clr_wr)  r_mem[r_clr_addr] <= G_RST_VAL;
        else if (w_wr) r_mem[w_idx]      <= w_new;
    end

`ifdef SP_RAM_PARITY_EN
    logic [G_BYTES-1:0] r_par [G_DEPTH];
    logic [G_BYTES-1:0] w_par_old, w_par_din, w_par_rst, w_par_new, w_par_chk;

    always_comb begin
        w_par_din = '0;
        w_par_rst = '0;
        w_par_chk = '0;
        for (int b = 0; b < G_BYTES; b++) begin
            w_par_din[b] = ^din[8*b +: 8];
            w_par_rst[b] = ^G_RST_VAL[8*b +: 8];
            w_par_chk[b] = (^w_old[8*b +: 8]) ^ w_par_old[b];
        end
    end

    assign w_par_old = w_in_rng ? r_par[w_idx] : '0;
    assign w_par_new = (w_par_old & ~be) | (w_par_din & be);
    // Freshly written bytes of a write-first echo carry no stored error
    assign w_perr_in = (we && c_WF) ? (w_par_chk & ~be & {G_BYTES{w_in_rng}})
                                    : (w_par_chk & {G_BYTES{w_in_rng}});

    always_ff @(posedge clk) begin
        if (w_clr_wr)  r_par[r_clr_addr] <= w_par_rst;
        else if (w_wr) r_par[w_idx]      <= w_par_new;
    end
`else
    assign w_perr_in = '0;
`endif

    // ---------------- latency pipeline ----------------
    // Data stages load only with a valid token, so the last stage holds dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < G_PIPELINE; i++) begin
                r_vld_pipe[i]  <= 1'b0;
                r_dat_pipe[i]  <= G_RST_VAL;
                r_perr_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_vld_in;
            if (w_vld_in) begin
                r_dat_pipe[0]  <= w_dat_in;
                r_perr_pipe[0] <= w_perr_in;
            end
            for (int i = 1; i < G_PIPELINE; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                if (r_vld_pipe[i-1]) begin
                    r_dat_pipe[i]  <= r_dat_pipe[i-1];
                    r_perr_pipe[i] <= r_perr_pipe[i-1];
                end
            end
        end
    end

    assign dvld = r_vld_pipe[G_PIPELINE-1];
    assign dout = r_dat_pipe[G_PIPELINE-1];
    assign perr = r_perr_pipe[G_PIPELINE-1] & {G_BYTES{dvld}};

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_be
// Purpose  : Three sp_ram_be variants (latency/mode/depth) driven in lockstep
//            and compared every cycle against an array/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_be;

`ifdef SP_RAM_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, req, we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] din;

    logic [15:0] dout   [3];
    logic        dvld   [3];
    logic [1:0]  perr   [3];
    logic        clrrdy [3];

    // variant table: latency, depth, mode (0 NO_CHANGE, 1 WRITE_FIRST, 2 READ_FIRST), fill
    int          lat   [3] = '{1, 3, 2};
    int          depth [3] = '{16, 16, 12};
    int          mode  [3] = '{0, 1, 2};
    logic [15:0] rv    [3] = '{16'h0000, 16'h0000, 16'hBEEF};

    sp_ram_be #(.G_ADDR(4), .G_BYTES(2), .G_DEPTH(16), .G_PIPELINE(1),
                .G_WR_MODE("NO_CHANGE"), .G_CLR_ON_RST(1), .G_RST_VAL(16'h0000)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clrrdy(clrrdy[0]), .req(req), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout[0]), .dvld(dvld[0]), .perr(perr[0]));

    sp_ram_be #(.G_ADDR(4), .G_BYTES(2), .G_DEPTH(16), .G_PIPELINE(3),
                .G_WR_MODE("WRITE_FIRST"), .G_CLR_ON_RST(1), .G_RST_VAL(16'h0000)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clrrdy(clrrdy[1]), .req(req), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout[1]), .dvld(dvld[1]), .perr(perr[1]));

    sp_ram_be #(.G_ADDR(4), .G_BYTES(2), .G_DEPTH(12), .G_PIPELINE(2),
                .G_WR_MODE("READ_FIRST"), .G_CLR_ON_RST(1), .G_RST_VAL(16'hBEEF)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .clrrdy(clrrdy[2]), .req(req), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout[2]), .dvld(dvld[2]), .perr(perr[2]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h required=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_mem  [3][16];
    logic [1:0]  m_bad  [3][16];   // bytes whose stored data was corrupted behind the RAM's back
    int          m_left [3];       // clear cycles still to run, 0 = ready
    logic [15:0] m_last [3];
    bit          s_vld  [3][64];   // expected output per cycle slot
    logic [15:0] s_dat  [3][64];
    logic [1:0]  s_perr [3][64];
    int          e = 0;

    task automatic sched(input int k, input logic [15:0] d, input logic [1:0] pe);
        int sl;
        sl = (e + lat[k] - 1) % 64;
        s_vld[k][sl]  = 1'b1;
        s_dat[k][sl]  = d;
        s_perr[k][sl] = c_PAR ? pe : 2'b00;
    endtask

    task automatic model_access(input int k);
        logic [15:0] old, nw;
        logic [1:0]  bad;
        bit          inr;
        inr = int'(addr) < depth[k];
        old = inr ? m_mem[k][addr] : rv[k];
        bad = inr ? m_bad[k][addr] : 2'b00;
        if (!we) begin
            sched(k, old, bad);
        end else begin
            nw = old;
            if (be[0]) nw[7:0]  = din[7:0];
            if (be[1]) nw[15:8] = din[15:8];
            if (inr) begin
                m_mem[k][addr] = nw;
                m_bad[k][addr] = bad & ~be;
            end
            if (mode[k] == 1)      sched(k, nw, bad & ~be);
            else if (mode[k] == 2) sched(k, old, bad);
        end
    endtask

    always @(posedge clk) begin
        e++;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                for (int s = 0; s < 64; s++) s_vld[k][s] = 1'b0;
                m_left[k] = depth[k];
                m_last[k] = rv[k];
            end else if (m_left[k] > 0) begin
                m_mem[k][depth[k] - m_left[k]] = rv[k];
                m_bad[k][depth[k] - m_left[k]] = 2'b00;
                m_left[k]--;
            end else begin
                if (req) model_access(k);
                if (clr) m_left[k] = depth[k];
            end
        end
    end

    always @(negedge clk) begin
        int sl;
        if (e > 0) begin
            sl = e % 64;
            for (int k = 0; k < 3; k++) begin
                chk("dvld", k, 32'(dvld[k]), 32'(s_vld[k][sl]));
                if (s_vld[k][sl]) m_last[k] = s_dat[k][sl];
                chk("dout", k, 32'(dout[k]), 32'(m_last[k]));
                chk("perr", k, 32'(perr[k]), s_vld[k][sl] ? 32'(s_perr[k][sl]) : 32'd0);
                chk("clrrdy", k, 32'(clrrdy[k]), (m_left[k] == 0) ? 32'd1 : 32'd0);
                s_vld[k][sl] = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rq, input bit w, input logic [1:0] b, input logic [3:0] a,
                         input logic [15:0] d, input bit c);
        @(negedge clk);
        #1;
        req = rq; we = w; be = b; addr = a; din = d; clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
    endtask

    // Literal pins: each variant is examined exactly lat cycles after the last issued access
    task automatic lit(input string nm, input logic [15:0] x0, input logic [15:0] x1,
                       input logic [15:0] x2, input bit v0, input bit v1, input bit v2,
                       input logic [1:0] pe);
        logic [15:0] xe [3];
        bit          ve [3];
        xe = '{x0, x1, x2};
        ve = '{v0, v1, v2};
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (lat[k] == c) begin
                    chk({nm, "_vld"}, k, 32'(dvld[k]), 32'(ve[k]));
                    if (ve[k]) begin
                        chk({nm, "_dat"}, k, 32'(dout[k]), 32'(xe[k]));
                        chk({nm, "_perr"}, k, 32'(perr[k]), 32'(pe));
                    end
                end
            end
            #1;
            req = 1'b0; clr = 1'b0;
        end
    endtask

    initial begin
        int cnt [3];
        bit rp;
        rst_n = 1'b0; clr = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00; addr = 4'd0; din = 16'h0000;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_dvld", k, 32'(dvld[k]), 32'd0);
            chk("rst_dout", k, 32'(dout[k]), 32'(rv[k]));
            chk("rst_clrrdy", k, 32'(clrrdy[k]), 32'd0);
        end
        #1 rst_n = 1'b1;

        // clear length after reset release
        cnt = '{0, 0, 0};
        #1;
        for (int k = 0; k < 3; k++) if (!clrrdy[k]) cnt[k]++;
        repeat (20) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (!clrrdy[k]) cnt[k]++;
        end
        for (int k = 0; k < 3; k++) chk("clr_len", k, 32'(cnt[k]), 32'(depth[k]));

        for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, 2'b00, 4'(a), 16'h0000, 1'b0);
        idle(4);
        drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b0);
        lit("clrval", 16'h0000, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 1'b1, 2'b00);

        // byte-enable merge and write-mode echo
        drive(1'b1, 1'b1, 2'b11, 4'd3, 16'hA5A5, 1'b0);
        drive(1'b1, 1'b1, 2'b01, 4'd3, 16'h1234, 1'b0);
        lit("wmode", 16'h0000, 16'hA534, 16'hA5A5, 1'b0, 1'b1, 1'b1, 2'b00);
        drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0);
        lit("rd3", 16'hA534, 16'hA534, 16'hA534, 1'b1, 1'b1, 1'b1, 2'b00);

        // read right after write to the same address
        drive(1'b1, 1'b1, 2'b10, 4'd3, 16'h7700, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0);
        lit("raw", 16'h7734, 16'h7734, 16'h7734, 1'b1, 1'b1, 1'b1, 2'b00);

        // address beyond depth on the 12-word variant
        drive(1'b1, 1'b1, 2'b11, 4'd13, 16'h5555, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 4'd13, 16'h0000, 1'b0);
        lit("oor", 16'h5555, 16'h5555, 16'hBEEF, 1'b1, 1'b1, 1'b1, 2'b00);

        // corrupt one stored bit of byte 1 at address 5
        drive(1'b1, 1'b1, 2'b11, 4'd5, 16'h0F0F, 1'b0);
        idle(4);
        u0.r_mem[5] = 16'h0E0F;
        u1.r_mem[5] = 16'h0E0F;
        u2.r_mem[5] = 16'h0E0F;
        for (int k = 0; k < 3; k++) begin
            m_mem[k][5] = 16'h0E0F;
            m_bad[k][5] = 2'b10;
        end
        drive(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b0);
        lit("par", 16'h0E0F, 16'h0E0F, 16'h0E0F, 1'b1, 1'b1, 1'b1, c_PAR ? 2'b10 : 2'b00);

        // reset flushes reads in flight
        drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 4'd5, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0000, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0; req = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("flush_dvld", k, 32'(dvld[k]), 32'd0);
            chk("flush_dout", k, 32'(dout[k]), 32'(rv[k]));
        end
        idle(2);
        rst_n = 1'b1;
        idle(18);

        // clr pulse under continuous requests, then reset halfway through the clear
        for (int i = 0; i < 14; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 16'($urandom), i == 4);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("midclr_dvld", k, 32'(dvld[k]), 32'd0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 16'($urandom), 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
                  16'($urandom), $urandom_range(0, 79) == 0);
            rp = ($urandom_range(0, 249) == 0);
            rst_n = !rp;
        end
        rst_n = 1'b1;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
